// File: rtl/jesd204_scrambler_pkg.sv
// Shared constants and helpers for the JESD204B multi-lane scrambler (1 + x^14 + x^15).
package jesd204_scrambler_pkg;

    localparam int POLY_LEN = 15;
    localparam int TAP_A = 14;
    localparam int TAP_B = 15;
    localparam logic [POLY_LEN-1:0] SEED_DEFAULT = 15'h7fff;
    localparam int LOCK_CNT_W = 4;

    // Beats needed before a descrambler lane has flushed its unknown history.
    function automatic int lock_beats(input int w);
        return (POLY_LEN + w - 1) / w;
    endfunction

    // Serial bit n of a lane word: octet n/8 first, bit 7 of each octet first.
    function automatic int serial_pos(input int n);
        return 8 * (n / 8) + 7 - (n % 8);
    endfunction

endpackage

// File: rtl/jesd204_scrambler_lane.sv
// One lane: 15-bit line-side history, word-wide unrolled (de)scrambling and lock counter.
module jesd204_scrambler_lane
    import jesd204_scrambler_pkg::*;
#(
    parameter int W = 32,
    parameter bit DESCRAMBLE = 1'b0,
    parameter logic [POLY_LEN-1:0] SEED = SEED_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] in_word,
    output logic [W-1:0] out_word,
    output logic         locked
);

    logic [POLY_LEN-1:0] state_reg;
    logic [POLY_LEN-1:0] state_next;
    logic [POLY_LEN-1:0] start_state;
    logic [W-1:0]        proc_word;

    // A coincident seed load means this beat already starts from SEED.
    assign start_state = load ? SEED : state_reg;

    // state bit j holds the line bit seen j+1 positions ago.
    always_comb begin
        logic [POLY_LEN-1:0] st;
        logic                fb;
        logic                line_bit;
        st        = start_state;
        proc_word = '0;
        for (int i = 0; i < W; i++) begin
            fb = st[TAP_A-1] ^ st[TAP_B-1];
            if (DESCRAMBLE) begin
                line_bit                  = in_word[serial_pos(i)];
                proc_word[serial_pos(i)]  = in_word[serial_pos(i)] ^ fb;
            end else begin
                line_bit                  = in_word[serial_pos(i)] ^ fb;
                proc_word[serial_pos(i)]  = line_bit;
            end
            st = {st[POLY_LEN-2:0], line_bit};
        end
        state_next = st;
    end

    assign out_word = enable ? proc_word : in_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SEED;
        end else if (advance) begin
            state_reg <= state_next;
        end else if (load) begin
            state_reg <= SEED;
        end
    end

    if (DESCRAMBLE) begin : g_lock_dsc
        localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(lock_beats(W));
        logic [LOCK_CNT_W-1:0] lock_cnt_reg;
        logic [LOCK_CNT_W-1:0] lock_cnt_next;

        always_comb begin
            lock_cnt_next = lock_cnt_reg;
            if (load) begin
                lock_cnt_next = advance ? LOCK_CNT_W'(1) : '0;
            end else if (advance && lock_cnt_reg != LOCK_MAX) begin
                lock_cnt_next = lock_cnt_reg + LOCK_CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lock_cnt_reg <= '0;
            end else begin
                lock_cnt_reg <= lock_cnt_next;
            end
        end

        assign locked = (lock_cnt_reg == LOCK_MAX);
    end else begin : g_lock_scr
        logic out_of_reset_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_of_reset_reg <= 1'b0;
            end else begin
                out_of_reset_reg <= 1'b1;
            end
        end

        assign locked = out_of_reset_reg;
    end

endmodule

// File: rtl/jesd204_scrambler_multilane.sv
// Multi-lane JESD204B scrambler/descrambler with a one-deep registered valid/ready output stage.
module jesd204_scrambler_multilane
    import jesd204_scrambler_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OCTETS = 4,
    parameter bit DESCRAMBLE = 1'b0,
    parameter logic [POLY_LEN-1:0] SEED = SEED_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            enable,
    input  logic                        seed_load,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*8*OCTETS-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*8*OCTETS-1:0]   out_data,
    output logic [LANES-1:0]            locked
);

    localparam int W = 8 * OCTETS;

    logic               accept;
    logic               out_valid_reg;
    logic [LANES*W-1:0] out_data_reg;
    logic [LANES*W-1:0] lane_out;

    assign in_ready = out_ready | ~out_valid_reg;
    assign accept   = in_valid & in_ready;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        jesd204_scrambler_lane #(
            .W          (W),
            .DESCRAMBLE (DESCRAMBLE),
            .SEED       (SEED)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .advance  (accept),
            .load     (seed_load),
            .enable   (enable[gi]),
            .in_word  (in_data[gi*W +: W]),
            .out_word (lane_out[gi*W +: W]),
            .locked   (locked[gi])
        );
    end

    // Output register holds its beat until accepted downstream or replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= lane_out;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_jesd204_scrambler_multilane.sv
// Directed/random bench: 4x32 scrambler, 4x32 descrambler (seed 0), 2x8 descrambler (seed 0).
`timescale 1ns/1ps
module tb_jesd204_scrambler_multilane;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [3:0]   s_en, s_lk;
    logic         s_ld, s_iv, s_ir, s_ov, s_or;
    logic [127:0] s_id, s_od;
    logic [3:0]   d_en, d_lk;
    logic         d_ld, d_iv, d_ir, d_ov, d_or;
    logic [127:0] d_id, d_od;
    logic [1:0]   e_en, e_lk;
    logic         e_ld, e_iv, e_ir, e_ov, e_or;
    logic [15:0]  e_id, e_od;

    jesd204_scrambler_multilane #(.LANES(4), .OCTETS(4), .DESCRAMBLE(1'b0), .SEED(15'h7fff)) u_scr (
        .clk(clk), .rst(rst), .enable(s_en), .seed_load(s_ld), .in_valid(s_iv), .in_ready(s_ir),
        .in_data(s_id), .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .locked(s_lk));
    jesd204_scrambler_multilane #(.LANES(4), .OCTETS(4), .DESCRAMBLE(1'b1), .SEED(15'h0000)) u_dsc (
        .clk(clk), .rst(rst), .enable(d_en), .seed_load(d_ld), .in_valid(d_iv), .in_ready(d_ir),
        .in_data(d_id), .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .locked(d_lk));
    jesd204_scrambler_multilane #(.LANES(2), .OCTETS(1), .DESCRAMBLE(1'b1), .SEED(15'h0000)) u_dsc1 (
        .clk(clk), .rst(rst), .enable(e_en), .seed_load(e_ld), .in_valid(e_iv), .in_ready(e_ir),
        .in_data(e_id), .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .locked(e_lk));

    int checks = 0;
    int failures = 0;

    // Reference model: full serial line history per (instance, lane); inst 3 is a model-only 2x8 scrambler.
    bit line_h [16][8192];
    int n_h [16];
    int beats_h [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_seed(input int inst);
        logic [14:0] sd;
        sd = (inst == 1 || inst == 2) ? 15'h0000 : 15'h7fff;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 15; j++) line_h[inst*4+l][14-j] = sd[j];
            n_h[inst*4+l] = 15;
        end
        beats_h[inst] = 0;
    endtask

    task automatic model_word(input int h, input int w, input bit desc, input bit en,
                              input logic [63:0] din, output logic [63:0] dout);
        int pos, n;
        bit fb, lb;
        dout = '0;
        for (int i = 0; i < w; i++) begin
            pos = 8 * (i / 8) + 7 - (i % 8);
            n = n_h[h];
            fb = line_h[h][n-14] ^ line_h[h][n-15];
            lb = desc ? din[pos] : (din[pos] ^ fb);
            line_h[h][n] = lb;
            n_h[h] = n + 1;
            dout[pos] = en ? (desc ? (din[pos] ^ fb) : lb) : din[pos];
        end
    endtask

    task automatic model_beat(input int inst, input logic [127:0] data, input logic [3:0] en,
                              input bit ld, output logic [127:0] exp, output logic [3:0] lk_exp);
        int lanes, w, lb;
        bit desc;
        logic [63:0] din, dout;
        lanes = (inst >= 2) ? 2 : 4;
        w     = (inst >= 2) ? 8 : 32;
        desc  = (inst == 1 || inst == 2);
        lb    = (15 + w - 1) / w;
        if (ld) model_seed(inst);
        exp = '0;
        for (int l = 0; l < lanes; l++) begin
            din = 64'(data >> (l * w));
            din = (w == 8) ? (din & 64'hff) : (din & 64'hffff_ffff);
            model_word(inst*4 + l, w, desc, en[l], din, dout);
            exp = exp | (128'(dout) << (l * w));
        end
        beats_h[inst]++;
        if (!desc) lk_exp = (lanes == 2) ? 4'h3 : 4'hF;
        else if (beats_h[inst] >= lb) lk_exp = (lanes == 2) ? 4'h3 : 4'hF;
        else lk_exp = 4'h0;
    endtask

    task automatic beat(input int inst, input logic [127:0] data, input logic [3:0] en,
                        input bit ld, output logic [127:0] exp);
        logic [3:0]   lk_exp, obs_lk;
        logic [127:0] obs_d;
        logic         obs_v;
        model_beat(inst, data, en, ld, exp, lk_exp);
        case (inst)
            0:       begin s_id = data; s_en = en; s_ld = ld; s_iv = 1'b1; s_or = 1'b1; end
            1:       begin d_id = data; d_en = en; d_ld = ld; d_iv = 1'b1; d_or = 1'b1; end
            default: begin e_id = data[15:0]; e_en = en[1:0]; e_ld = ld; e_iv = 1'b1; e_or = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        case (inst)
            0:       begin s_iv = 1'b0; s_ld = 1'b0; obs_v = s_ov; obs_d = s_od; obs_lk = s_lk; end
            1:       begin d_iv = 1'b0; d_ld = 1'b0; obs_v = d_ov; obs_d = d_od; obs_lk = d_lk; end
            default: begin e_iv = 1'b0; e_ld = 1'b0; obs_v = e_ov; obs_d = 128'(e_od); obs_lk = 4'(e_lk); end
        endcase
        $display("beat inst=%0d ld=%0d en=%h in=%h out=%h lock=%h", inst, ld, en, data, obs_d, obs_lk);
        chk($sformatf("valid_i%0d", inst), 128'(obs_v), 128'(1'b1));
        chk($sformatf("data_i%0d", inst), obs_d, exp);
        chk($sformatf("lock_i%0d", inst), 128'(obs_lk), 128'(lk_exp));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] data, e, e0, sd;
        logic [3:0]   lk, en;
        rst = 1'b1;
        s_en = 4'hF; s_ld = 0; s_iv = 0; s_or = 0; s_id = '0;
        d_en = 4'hF; d_ld = 0; d_iv = 0; d_or = 0; d_id = '0;
        e_en = 2'h3; e_ld = 0; e_iv = 0; e_or = 0; e_id = '0;
        for (int i = 0; i < 4; i++) model_seed(i);

        // Reset state
        #2;
        chk("rst_s_valid", 128'(s_ov), 128'(0));
        chk("rst_s_data", s_od, 128'(0));
        chk("rst_s_lock", 128'(s_lk), 128'(0));
        chk("rst_s_ready", 128'(s_ir), 128'(1));
        chk("rst_d_lock", 128'(d_lk), 128'(0));
        chk("rst_d_ready", 128'(d_ir), 128'(1));
        chk("rst_e_ready", 128'(e_ir), 128'(1));
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_s_lock", 128'(s_lk), 128'(4'hF));
        chk("post_rst_d_lock", 128'(d_lk), 128'(0));
        chk("post_rst_s_valid", 128'(s_ov), 128'(0));

        // Zero-word vector
        beat(0, '0, 4'hF, 1'b0, e);
        chk("zero_vec_lane0", 128'(s_od[31:0]), 128'(32'h0C000200));

        // Round trip 4x32: descrambler output equals scrambler input from beat 2
        for (int i = 0; i < 6; i++) begin
            data = rnd128();
            beat(0, data, 4'hF, 1'b0, sd);
            beat(1, s_od, 4'hF, 1'b0, e);
            if (i >= 1) chk("rt32_data", d_od, data);
            if (i == 0) chk("rt32_lock_first", 128'(d_lk), 128'(4'hF));
        end

        // Round trip 2x8: lock after 2 beats, data from beat 3
        for (int i = 0; i < 6; i++) begin
            data = 128'($urandom_range(0, 65535));
            model_beat(3, data, 4'h3, 1'b0, sd, lk);
            beat(2, sd, 4'h3, 1'b0, e);
            if (i >= 2) chk("rt8_data", 128'(e_od), data);
            if (i == 0) chk("rt8_lock_b1", 128'(e_lk), 128'(0));
            if (i == 1) chk("rt8_lock_b2", 128'(e_lk), 128'(2'h3));
        end

        // Backpressure: 5 stalled cycles, then stream resumes as if never stalled
        beat(0, rnd128(), 4'hF, 1'b0, e0);
        data = rnd128();
        s_or = 1'b0; s_iv = 1'b1; s_id = data; s_en = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_ready_low", 128'(s_ir), 128'(0));
            @(posedge clk); #1;
            chk("bp_valid_hold", 128'(s_ov), 128'(1));
            chk("bp_data_hold", s_od, e0);
        end
        model_beat(0, data, 4'hF, 1'b0, e, lk);
        s_or = 1'b1;
        @(posedge clk); #1;
        s_iv = 1'b0;
        chk("bp_release_data", s_od, e);
        beat(0, rnd128(), 4'hF, 1'b0, e);
        @(posedge clk); #1;
        chk("bp_idle_valid_drop", 128'(s_ov), 128'(0));

        // seed_load alone keeps the held output beat
        beat(0, rnd128(), 4'hF, 1'b0, e0);
        s_or = 1'b0; s_ld = 1'b1;
        @(posedge clk); #1;
        s_ld = 1'b0;
        chk("ld_hold_valid", 128'(s_ov), 128'(1));
        chk("ld_hold_data", s_od, e0);
        model_seed(0);
        beat(0, '0, 4'hF, 1'b0, e);
        chk("ld_idle_zero_vec", s_od, {4{32'h0C000200}});

        // seed_load coincident with a beat
        beat(0, rnd128(), 4'hF, 1'b0, e);
        beat(0, '0, 4'hF, 1'b1, e);
        chk("ld_beat_zero_vec", 128'(s_od[31:0]), 128'(32'h0C000200));
        beat(1, rnd128(), 4'hF, 1'b1, e);
        beat(2, rnd128(), 4'h3, 1'b0, e);
        beat(2, rnd128(), 4'h3, 1'b1, e);
        chk("ld_beat_lock_restart", 128'(e_lk), 128'(0));
        beat(2, rnd128(), 4'h3, 1'b0, e);

        // Bypass lane 1 for 3 beats
        for (int i = 0; i < 5; i++) begin
            data = rnd128();
            en = (i < 3) ? 4'b1101 : 4'hF;
            beat(0, data, en, 1'b0, e);
            if (i < 3) chk("bypass_lane1", 128'(s_od[63:32]), 128'(data[63:32]));
        end
        beat(1, rnd128(), 4'b1011, 1'b0, e);
        beat(1, rnd128(), 4'hF, 1'b0, e);

        // Async reset between edges with output valid
        beat(0, rnd128(), 4'hF, 1'b0, e);
        beat(1, rnd128(), 4'hF, 1'b0, e);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_valid", 128'(s_ov), 128'(0));
        chk("arst_s_data", s_od, 128'(0));
        chk("arst_s_lock", 128'(s_lk), 128'(0));
        chk("arst_d_valid", 128'(d_ov), 128'(0));
        chk("arst_d_data", d_od, 128'(0));
        chk("arst_d_lock", 128'(d_lk), 128'(0));
        chk("arst_e_lock", 128'(e_lk), 128'(0));
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) model_seed(i);
        beat(0, '0, 4'hF, 1'b0, e);
        chk("arst_seed_vec", 128'(s_od[31:0]), 128'(32'h0C000200));
        beat(1, rnd128(), 4'hF, 1'b0, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
